// File: rtl/ctrl_seq_if.sv
// Control bundle between fetch/datapath (master) and the ctrl_seq sequencer (slave).
interface ctrl_seq_if #(
    parameter int unsigned OP_W = 3
);
    logic            Start;
    logic [OP_W-1:0] Op;
    logic            Zero;
    logic [1:0]      WriteSrc;
    logic            ALUOp;
    logic            MemWrite;
    logic            BranchEn;
    logic            RegWrite;
    logic            SwapSel;
    logic            Stall;
    logic            Flush;
    logic            Illegal;
    logic [15:0]     InstrCnt;
    logic [15:0]     StallCnt;

    modport master (
        output Start, Op, Zero,
        input  WriteSrc, ALUOp, MemWrite, BranchEn, RegWrite, SwapSel, Stall, Flush, Illegal,
        input  InstrCnt, StallCnt
    );

    modport slave (
        input  Start, Op, Zero,
        output WriteSrc, ALUOp, MemWrite, BranchEn, RegWrite, SwapSel, Stall, Flush, Illegal,
        output InstrCnt, StallCnt
    );
endinterface

// File: rtl/ctrl_seq.sv
// Multi-cycle control sequencer: opcode decode plus load-wait, swap and branch-flush states.
// Define CTRL_SEQ_PERF_EN to build the saturating InstrCnt/StallCnt performance counters.
module ctrl_seq #(
    parameter int unsigned OP_W    = 3,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    ctrl_seq_if.slave  ctrl_io
);

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StLoadWait,
        StSwap2,
        StBFlush
    } state_e;

    localparam logic [3:0] LoadInit = 4'(MEM_LAT - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       illegal_q, illegal_d;

    logic [1:0] write_src;
    logic       alu_op, mem_write, branch_en, reg_write, swap_sel, stall, flush;

    logic       op_illegal;
    logic [2:0] op_lo;

    // Zero-extend so the compare is well formed for every OP_W, including 3.
    assign op_illegal = (32'(ctrl_io.Op) > 32'd7);
    assign op_lo      = ctrl_io.Op[2:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        write_src = 2'b11;
        alu_op    = 1'b0;
        mem_write = 1'b0;
        branch_en = 1'b0;
        reg_write = 1'b0;
        swap_sel  = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;

        unique case (state_q)
            StIdle: begin
                stall = 1'b1;
                if (ctrl_io.Start) state_d = StDecode;
            end
            StDecode: begin
                if (op_illegal) begin
                    illegal_d = 1'b1;
                end else begin
                    unique case (op_lo)
                        3'b000: begin
                            write_src = 2'b00;
                            reg_write = 1'b1;
                        end
                        3'b001: begin
                            write_src = 2'b00;
                            alu_op    = 1'b1;
                            reg_write = 1'b1;
                        end
                        3'b010: begin
                            write_src = 2'b01;
                            stall     = 1'b1;
                            cnt_d     = LoadInit;
                            state_d   = StLoadWait;
                        end
                        3'b011: mem_write = 1'b1;
                        3'b100: begin
                            write_src = 2'b10;
                            reg_write = 1'b1;
                        end
                        3'b101: begin
                            alu_op    = 1'b1;
                            branch_en = ctrl_io.Zero;
                            if (ctrl_io.Zero) state_d = StBFlush;
                        end
                        3'b110: begin
                            reg_write = 1'b1;
                            stall     = 1'b1;
                            state_d   = StSwap2;
                        end
                        3'b111: reg_write = 1'b1;
                    endcase
                end
            end
            StLoadWait: begin
                write_src = 2'b01;
                if (cnt_q != 4'd0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    reg_write = 1'b1;
                    state_d   = StDecode;
                end
            end
            StSwap2: begin
                reg_write = 1'b1;
                swap_sel  = 1'b1;
                state_d   = StDecode;
            end
            StBFlush: begin
                flush   = 1'b1;
                state_d = StDecode;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    assign ctrl_io.WriteSrc = write_src;
    assign ctrl_io.ALUOp    = alu_op;
    assign ctrl_io.MemWrite = mem_write;
    assign ctrl_io.BranchEn = branch_en;
    assign ctrl_io.RegWrite = reg_write;
    assign ctrl_io.SwapSel  = swap_sel;
    assign ctrl_io.Stall    = stall;
    assign ctrl_io.Flush    = flush;
    assign ctrl_io.Illegal  = illegal_q;

`ifdef CTRL_SEQ_PERF_EN
    logic [15:0] instr_cnt_q, instr_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        retire, stall_evt;

    // Lwd and swp leave DECODE without retiring; their final cycle retires instead.
    assign retire = ((state_q == StDecode) && ((state_d == StDecode) || (state_d == StBFlush)))
                 || ((state_q == StLoadWait) && (cnt_q == 4'd0))
                 || (state_q == StSwap2);
    assign stall_evt = stall && (state_q != StIdle);

    always_comb begin
        instr_cnt_d = instr_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (retire && (instr_cnt_q != 16'hFFFF)) instr_cnt_d = instr_cnt_q + 16'd1;
        if (stall_evt && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            instr_cnt_q <= 16'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            instr_cnt_q <= instr_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ctrl_io.InstrCnt = instr_cnt_q;
    assign ctrl_io.StallCnt = stall_cnt_q;
`else
    assign ctrl_io.InstrCnt = 16'd0;
    assign ctrl_io.StallCnt = 16'd0;
`endif

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq: one instance with OP_W=4/MEM_LAT=3, one with OP_W=3/MEM_LAT=2.
module tb_ctrl_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_a;
    logic reset_b;

    ctrl_seq_if #(.OP_W(4)) bus_a ();
    ctrl_seq_if #(.OP_W(3)) bus_b ();

    ctrl_seq #(.OP_W(4), .MEM_LAT(3)) u_dut_a (
        .Clk     (clk),
        .Reset   (reset_a),
        .ctrl_io (bus_a)
    );

    ctrl_seq #(.OP_W(3), .MEM_LAT(2)) u_dut_b (
        .Clk     (clk),
        .Reset   (reset_b),
        .ctrl_io (bus_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Packed order: WriteSrc, ALUOp, MemWrite, BranchEn, RegWrite, SwapSel, Stall, Flush, Illegal
    function automatic logic [9:0] ov(input logic [1:0] ws, input logic alu, input logic mw,
                                      input logic br, input logic rw, input logic ss,
                                      input logic st, input logic fl, input logic il);
        return {ws, alu, mw, br, rw, ss, st, fl, il};
    endfunction

    function automatic logic [9:0] obs_a();
        return {bus_a.WriteSrc, bus_a.ALUOp, bus_a.MemWrite, bus_a.BranchEn, bus_a.RegWrite,
                bus_a.SwapSel, bus_a.Stall, bus_a.Flush, bus_a.Illegal};
    endfunction

    function automatic logic [9:0] obs_b();
        return {bus_b.WriteSrc, bus_b.ALUOp, bus_b.MemWrite, bus_b.BranchEn, bus_b.RegWrite,
                bus_b.SwapSel, bus_b.Stall, bus_b.Flush, bus_b.Illegal};
    endfunction

    task automatic step_a(input string tag, input logic [3:0] op, input logic zero,
                          input logic start, input logic [9:0] exp);
        @(negedge clk);
        bus_a.Op    = op;
        bus_a.Zero  = zero;
        bus_a.Start = start;
        #1;
        check_eq(tag, 32'(obs_a()), 32'(exp));
    endtask

    task automatic step_b(input string tag, input logic [2:0] op, input logic zero,
                          input logic start, input logic [9:0] exp);
        @(negedge clk);
        bus_b.Op    = op;
        bus_b.Zero  = zero;
        bus_b.Start = start;
        #1;
        check_eq(tag, 32'(obs_b()), 32'(exp));
    endtask

    logic [15:0] exp_instr;
    logic [15:0] exp_stall;

    initial begin
        reset_a     = 1'b0;
        reset_b     = 1'b0;
        bus_a.Start = 1'b0;
        bus_a.Op    = '0;
        bus_a.Zero  = 1'b0;
        bus_b.Start = 1'b0;
        bus_b.Op    = '0;
        bus_b.Zero  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_a = 1'b1;
        reset_b = 1'b1;
        #1;
        check_eq("a_reset_idle", 32'(obs_a()), 32'(ov(2'b11, 0, 0, 0, 0, 0, 1, 0, 0)));
        check_eq("a_reset_instr", 32'(bus_a.InstrCnt), 32'd0);
        check_eq("a_reset_stall", 32'(bus_a.StallCnt), 32'd0);
        check_eq("b_reset_idle", 32'(obs_b()), 32'(ov(2'b11, 0, 0, 0, 0, 0, 1, 0, 0)));

        // Idle, then Start
        step_a("a_idle", 4'd0, 0, 0, ov(2'b11, 0, 0, 0, 0, 0, 1, 0, 0));
        step_a("a_start", 4'd0, 0, 1, ov(2'b11, 0, 0, 0, 0, 0, 1, 0, 0));

        // Back-to-back single-cycle ops; Start held high must be ignored
        step_a("a_add", 4'd0, 0, 1, ov(2'b00, 0, 0, 0, 1, 0, 0, 0, 0));
        step_a("a_sub", 4'd1, 0, 0, ov(2'b00, 1, 0, 0, 1, 0, 0, 0, 0));
        step_a("a_slt", 4'd4, 0, 0, ov(2'b10, 0, 0, 0, 1, 0, 0, 0, 0));
        step_a("a_swd", 4'd3, 0, 0, ov(2'b11, 0, 1, 0, 0, 0, 0, 0, 0));
        step_a("a_lim", 4'd7, 0, 0, ov(2'b11, 0, 0, 0, 1, 0, 0, 0, 0));

        // lwd with MEM_LAT=3: three stall cycles, RegWrite in the fourth
        step_a("a_lwd_dec", 4'd2, 0, 0, ov(2'b01, 0, 0, 0, 0, 0, 1, 0, 0));
        step_a("a_lwd_w1", 4'd1, 0, 0, ov(2'b01, 0, 0, 0, 0, 0, 1, 0, 0));
        step_a("a_lwd_w2", 4'd1, 0, 0, ov(2'b01, 0, 0, 0, 0, 0, 1, 0, 0));
        step_a("a_lwd_wr", 4'd1, 0, 0, ov(2'b01, 0, 0, 0, 1, 0, 0, 0, 0));
        step_a("a_lwd_next", 4'd0, 0, 0, ov(2'b00, 0, 0, 0, 1, 0, 0, 0, 0));

        // swp then add
        step_a("a_swp1", 4'd6, 0, 0, ov(2'b11, 0, 0, 0, 1, 0, 1, 0, 0));
        step_a("a_swp2", 4'd6, 0, 0, ov(2'b11, 0, 0, 0, 1, 1, 0, 0, 0));
        step_a("a_swp_add", 4'd0, 0, 0, ov(2'b00, 0, 0, 0, 1, 0, 0, 0, 0));

        // beq taken then not taken
        step_a("a_beq_t", 4'd5, 1, 0, ov(2'b11, 1, 0, 1, 0, 0, 0, 0, 0));
        step_a("a_bflush", 4'd5, 1, 0, ov(2'b11, 0, 0, 0, 0, 0, 0, 1, 0));
        step_a("a_beq_nt", 4'd5, 0, 0, ov(2'b11, 1, 0, 0, 0, 0, 0, 0, 0));
        step_a("a_beq_nt_next", 4'd0, 0, 0, ov(2'b00, 0, 0, 0, 1, 0, 0, 0, 0));

        // Illegal opcode with Zero=1: NOP, no branch; sticky flag from next cycle
        step_a("a_illegal", 4'b1010, 1, 0, ov(2'b11, 0, 0, 0, 0, 0, 0, 0, 0));
        step_a("a_illegal_set", 4'd0, 0, 0, ov(2'b00, 0, 0, 0, 1, 0, 0, 0, 1));
        for (int i = 0; i < 10; i++) begin
            step_a("a_illegal_sticky", 4'd1, 0, 0, ov(2'b00, 1, 0, 0, 1, 0, 0, 0, 1));
        end

        // Reset mid-LOADWAIT: back to IDLE, flag cleared, no write
        step_a("a_lwd2_dec", 4'd2, 0, 0, ov(2'b01, 0, 0, 0, 0, 0, 1, 0, 1));
        step_a("a_lwd2_w1", 4'd0, 0, 0, ov(2'b01, 0, 0, 0, 0, 0, 1, 0, 1));
        @(negedge clk);
        reset_a = 1'b0;
        #1;
        check_eq("a_rst_mid_lw", 32'(obs_a()), 32'(ov(2'b01, 0, 0, 0, 0, 0, 1, 0, 1)));
        @(negedge clk);
        reset_a = 1'b1;
        #1;
        check_eq("a_rst_idle", 32'(obs_a()), 32'(ov(2'b11, 0, 0, 0, 0, 0, 1, 0, 0)));
        step_a("a_rst_idle2", 4'd0, 0, 0, ov(2'b11, 0, 0, 0, 0, 0, 1, 0, 0));

        // Instance B, MEM_LAT=2: lwd + swp, then read the perf counters
        step_b("b_start", 3'd0, 0, 1, ov(2'b11, 0, 0, 0, 0, 0, 1, 0, 0));
        step_b("b_lwd_dec", 3'd2, 0, 0, ov(2'b01, 0, 0, 0, 0, 0, 1, 0, 0));
        step_b("b_lwd_w1", 3'd0, 0, 0, ov(2'b01, 0, 0, 0, 0, 0, 1, 0, 0));
        step_b("b_lwd_wr", 3'd0, 0, 0, ov(2'b01, 0, 0, 0, 1, 0, 0, 0, 0));
        step_b("b_swp1", 3'd6, 0, 0, ov(2'b11, 0, 0, 0, 1, 0, 1, 0, 0));
        step_b("b_swp2", 3'd6, 0, 0, ov(2'b11, 0, 0, 0, 1, 1, 0, 0, 0));
        step_b("b_swd", 3'd3, 0, 0, ov(2'b11, 0, 1, 0, 0, 0, 0, 0, 0));
`ifdef CTRL_SEQ_PERF_EN
        exp_instr = 16'd2;
        exp_stall = 16'd3;
`else
        exp_instr = 16'd0;
        exp_stall = 16'd0;
`endif
        check_eq("b_instr_cnt", 32'(bus_b.InstrCnt), 32'(exp_instr));
        check_eq("b_stall_cnt", 32'(bus_b.StallCnt), 32'(exp_stall));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_seq.md
# ctrl_seq

Multi-cycle control sequencer: the next generation of the single-cycle `Ctrl` opcode decoder. It sits between the instruction ROM/fetch unit and the datapath. It decodes an opcode of parametrised width and drives the same datapath controls: `WriteSrc`, `ALUOp`, `MemWrite`, `BranchEn`. It adds a state machine for variable-latency loads, two-cycle swaps and taken-branch flushes, plus a PC stall output, a register-write strobe and sticky illegal-opcode detection.

## Interface
Parameters:
- `OP_W`, default 3: opcode width, ≥3. Codes ≥8 are illegal.
- `MEM_LAT`, default 2: data-memory read latency in cycles, 1..15.

Ports:
- `Clk` in 1: single clock. All state updates on the rising edge.
- `Reset` in 1: synchronous, active-low.
- `Start` in 1: leaves IDLE. Sampled only in IDLE.
- `Op` in `OP_W`: opcode from the instruction ROM, valid every cycle.
- `Zero` in 1: ALU zero flag, same cycle as `Op`.
- `WriteSrc` out 2: register-write mux select. 00 = ALU, 01 = memory, 10 = slt, 11 = none/swap.
- `ALUOp` out 1: 0 = add, 1 = sub.
- `MemWrite` out 1: data-memory write enable.
- `BranchEn` out 1: branch taken this cycle.
- `RegWrite` out 1: register-file write strobe.
- `SwapSel` out 1: 0 = first swap destination, 1 = second.
- `Stall` out 1: hold PC/instruction this cycle.
- `Flush` out 1: bubble cycle; datapath discards `Op`.
- `Illegal` out 1: sticky illegal-opcode flag.
- `InstrCnt` out 16, `StallCnt` out 16: performance counters (see Configuration).

## Operation
- States: IDLE, DECODE, LOADWAIT, SWAP2, BFLUSH. Outputs are Mealy: a function of state, plus `Op`/`Zero` in DECODE.
- Default for every output in every cycle is 0, except `WriteSrc` = 11. Only deviations are listed below.
- IDLE: `Stall`=1. `Start`=1 → DECODE.
- DECODE, by opcode:
  - 000 add: `WriteSrc`=00, `RegWrite`=1.
  - 001 sub: `WriteSrc`=00, `ALUOp`=1, `RegWrite`=1.
  - 010 lwd: `WriteSrc`=01, `Stall`=1. Load counter with `MEM_LAT`-1 → LOADWAIT.
  - 011 swd: `MemWrite`=1.
  - 100 slt: `WriteSrc`=10, `RegWrite`=1.
  - 101 beq: `ALUOp`=1, `BranchEn`=`Zero`. If `Zero`=1 → BFLUSH, else stay in DECODE.
  - 110 swp: `RegWrite`=1, `SwapSel`=0, `Stall`=1 → SWAP2.
  - 111 lim: `WriteSrc`=11, `RegWrite`=1.
  - ≥8 (only when `OP_W`>3): behaves as NOP; `Illegal` sets on the next edge and stays set until reset.
- LOADWAIT: `WriteSrc`=01.
  - Counter ≠0: `Stall`=1, decrement.
  - Counter =0: `RegWrite`=1, `Stall`=0 → DECODE.
- SWAP2: `RegWrite`=1, `SwapSel`=1, `Stall`=0 → DECODE.
- BFLUSH: `Flush`=1, all enables 0, `Stall`=0 → DECODE.
- Counter width is 4 bits, which covers the full `MEM_LAT` range.

## Timing
- Reset (`Reset`=0 at an edge): state IDLE, counter 0, `Illegal` 0, perf counters 0.
  - Output values while in IDLE: `Stall`=1, `WriteSrc`=11, every other output 0.
  - Reset takes priority over every in-flight state, including mid-LOADWAIT and mid-SWAP2; no pending write completes.
- Latency, total cycles per instruction:
  - lwd: `MEM_LAT`+1, `RegWrite` on the last cycle only.
  - swp: 2.
  - taken beq: 2.
  - all others: 1.
- `Op` is ignored outside DECODE. Fetch holds it via `Stall`.
- With `MEM_LAT`=1: lwd is DECODE then one LOADWAIT cycle with `RegWrite`=1.
- `Start`=1 outside IDLE has no effect.
- Illegal opcode and `Zero`=1 in the same cycle: NOP, no branch.

## Configuration
- `CTRL_SEQ_PERF_EN` defined:
  - `InstrCnt` increments on each instruction retirement: every DECODE exit to DECODE/BFLUSH, the final LOADWAIT cycle, and the SWAP2 cycle.
  - `StallCnt` increments on each cycle with `Stall`=1 outside IDLE.
  - Both saturate at 16'hFFFF and clear on reset.
- Not defined: both ports are tied to 0 and the counter logic is absent. The port list is unchanged.

## Test plan
- Reset, then `Start`=1, then `Op` 000,001,100,011,111 back-to-back → 5 cycles, `Stall` 0 throughout, `RegWrite` 1,1,1,0,1, `MemWrite` only on the 4th cycle, `WriteSrc` 00,00,10,11,11.
- `MEM_LAT`=3, lwd → `Stall`=1 for 3 cycles, `RegWrite`=1 only in the 4th cycle with `WriteSrc`=01; the next op decodes in cycle 5.
- swp then add → `RegWrite` 1,1,1 with `SwapSel` 0,1,0, `Stall` 1,0,0.
- beq with `Zero`=1 → `BranchEn`=1, then one cycle `Flush`=1. beq with `Zero`=0 → `BranchEn`=0, no flush.
- `OP_W`=4, `Op`=4'b1010 → no enables asserted, `Illegal`=1 from the next cycle, still 1 after 10 more legal ops. `Reset`=0 asserted mid-LOADWAIT → IDLE next cycle, `Illegal`=0, no `RegWrite`.
- `CTRL_SEQ_PERF_EN` defined, lwd (`MEM_LAT`=2) + swp → `InstrCnt`=2, `StallCnt`=3. Macro undefined → both counters read 0.
